reg_list_sequencer: RTL and testbench

- Parametrised sequential successor to the combinational lowest-set-bit encoder; used by the multicycle control FSM for LM/SM multiple-register transfers.
- Latches a register-list mask and issues one register index per accepted handshake, in ascending (LSB-first) or descending (MSB-first) order.
- Counts the transfers issued, then signals completion.
- Replaces ad-hoc mask clearing in the controller; gives one-bit-per-cycle stepping with backpressure and abort.

---
 rtl/reg_list_sequencer_if.sv | 27 ++
 rtl/reg_list_sequencer.sv | 111 +++++++++++
 tb/tb_reg_list_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_list_sequencer_if.sv
// Handshake bundle between the multicycle controller and the register-list sequencer.
// The controller owns start/mask/abort/idx_ready; the sequencer drives everything else.
interface reg_list_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             start;
    logic [WIDTH-1:0] mask;
    logic             abort;
    logic             idx_valid;
    logic [IDX_W-1:0] idx;
    logic             idx_ready;
    logic             last;
    logic [IDX_W:0]   count;
    logic             busy;
    logic             done;

    modport master (
        output start, mask, abort, idx_ready,
        input  idx_valid, idx, last, count, busy, done
    );

    modport slave (
        input  start, mask, abort, idx_ready,
        output idx_valid, idx, last, count, busy, done
    );
endinterface

// File: rtl/reg_list_sequencer.sv
// Steps through a latched register-list mask, one index per accepted handshake, LSB- or MSB-first.
// Latency: first index the cycle after start; done the cycle after the final handshake.
// Backpressure: idx/last/count hold while idx_valid && !idx_ready; abort wins over handshake and start.
module reg_list_sequencer #(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    reg_list_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [IDX_W:0]   count_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W-1:0] idx_d;
    logic             onehot_d;
    logic             fire;

    // Priority pick of the next bit purely from registered state keeps inputs off the output path.
    always_comb begin
        idx_d = '0;
        if (MSB_FIRST == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (rem_q[i]) idx_d = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (rem_q[i]) idx_d = IDX_W'(i);
            end
        end
    end

    assign onehot_d = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);
    assign fire     = valid_q && bus.idx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rem_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        if (bus.mask != '0) begin
                            rem_q   <= bus.mask;
                            valid_q <= 1'b1;
                            state   <= RUN;
                        end else begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        rem_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (fire) begin
                        rem_q   <= rem_q & ~(WIDTH'(1) << idx_d);
                        count_q <= count_q + {{IDX_W{1'b0}}, 1'b1};
                        if (onehot_d) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= FIN;
                        end
                    end
                end
                FIN: begin
                    rem_q  <= '0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rem_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.idx_valid = valid_q;
    assign bus.idx       = idx_d;
    assign bus.last      = valid_q && onehot_d;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_reg_list_sequencer.sv
// Drives an LSB-first and an MSB-first sequencer with identical stimulus and checks both
// against a list-based reference of which set bits remain to be issued.
module tb_reg_list_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] mask;
    logic       abort;
    logic       ready;

    int n_assert = 0;
    int n_fail   = 0;

    reg_list_sequencer_if #(.WIDTH(8)) if_l ();
    reg_list_sequencer_if #(.WIDTH(8)) if_m ();

    assign if_l.start     = start;
    assign if_l.mask      = mask;
    assign if_l.abort     = abort;
    assign if_l.idx_ready = ready;
    assign if_m.start     = start;
    assign if_m.mask      = mask;
    assign if_m.abort     = abort;
    assign if_m.idx_ready = ready;

    reg_list_sequencer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_l.slave)
    );

    reg_list_sequencer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_m.slave)
    );

    always #5 clk = ~clk;

    // Reference: ascending list of the set bits, a position in it, and the phase flags.
    int lst[$];
    int p       = 0;
    bit m_run   = 1'b0;
    bit m_fin   = 1'b0;
    int m_count = 0;

    task automatic model_reset();
        lst.delete();
        p       = 0;
        m_run   = 1'b0;
        m_fin   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_update(input bit s, input logic [7:0] m, input bit a, input bit r);
        if (a) begin
            if (m_run || m_fin) begin
                m_run = 1'b0;
                m_fin = 1'b0;
            end
        end else if (m_run) begin
            if (r) begin
                p++;
                m_count++;
                if (p == lst.size()) begin
                    m_run = 1'b0;
                    m_fin = 1'b1;
                end
            end
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (s) begin
            m_count = 0;
            p       = 0;
            lst.delete();
            for (int i = 0; i < 8; i++) if (m[i]) lst.push_back(i);
            if (lst.size() == 0) m_fin = 1'b1;
            else                 m_run = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit exp_last;
        exp_last = m_run && (p == lst.size() - 1);
        chk("lsb_valid", 32'(if_l.idx_valid), 32'(m_run));
        chk("msb_valid", 32'(if_m.idx_valid), 32'(m_run));
        chk("lsb_last",  32'(if_l.last),      32'(exp_last));
        chk("msb_last",  32'(if_m.last),      32'(exp_last));
        chk("lsb_busy",  32'(if_l.busy),      32'(m_run || m_fin));
        chk("msb_busy",  32'(if_m.busy),      32'(m_run || m_fin));
        chk("lsb_done",  32'(if_l.done),      32'(m_fin));
        chk("msb_done",  32'(if_m.done),      32'(m_fin));
        chk("lsb_count", 32'(if_l.count),     32'(m_count));
        chk("msb_count", 32'(if_m.count),     32'(m_count));
        if (m_run) begin
            chk("lsb_idx", 32'(if_l.idx), 32'(lst[p]));
            chk("msb_idx", 32'(if_m.idx), 32'(lst[lst.size() - 1 - p]));
        end
    endtask

    // Called at a negedge: apply inputs, advance one clock, check at the following negedge.
    task automatic step(input bit s, input logic [7:0] m, input bit a, input bit r);
        start = s;
        mask  = m;
        abort = a;
        ready = r;
        @(posedge clk);
        model_update(s, m, a, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(if_l.idx_valid | if_m.idx_valid), 32'd0);
        chk({tag, "_idx"},   32'(if_l.idx | if_m.idx),             32'd0);
        chk({tag, "_last"},  32'(if_l.last | if_m.last),           32'd0);
        chk({tag, "_busy"},  32'(if_l.busy | if_m.busy),           32'd0);
        chk({tag, "_done"},  32'(if_l.done | if_m.done),           32'd0);
        chk({tag, "_count"}, 32'(if_l.count | if_m.count),         32'd0);
    endtask

    initial begin
        logic [7:0] rm;
        reset_n = 1'b0;
        start   = 1'b0;
        mask    = '0;
        abort   = 1'b0;
        ready   = 1'b0;
        model_reset();
        @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        step(0, 8'h00, 0, 0);

        // Mixed mask, consumer always ready: 1,2,5,7 (LSB) and 7,5,2,1 (MSB).
        step(1, 8'hA6, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1);
        chk("a6_count_lsb", 32'(if_l.count), 32'd4);
        chk("a6_count_msb", 32'(if_m.count), 32'd4);

        // Empty mask: a lone done pulse and zero count.
        step(1, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Full mask with stalls; count must reach 8 without wrapping.
        step(1, 8'hFF, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 8'h00, 0, (i % 3) == 0);
        chk("ff_count", 32'(if_l.count), 32'd8);

        // Abort on the second handshake: no done, count stays 1, then a fresh start works.
        step(1, 8'h38, 0, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 1, 1);
        chk("abort_count", 32'(if_l.count), 32'd1);
        step(0, 8'h00, 0, 1);
        step(1, 8'h01, 0, 0);
        chk("restart_idx", 32'(if_l.idx), 32'd0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Abort in IDLE suppresses a coincident start.
        step(1, 8'h0F, 1, 1);
        step(0, 8'h00, 0, 1);

        // Start while busy must not disturb the running list.
        step(1, 8'h81, 0, 0);
        step(1, 8'h7E, 0, 1);
        step(1, 8'h7E, 0, 0);
        step(1, 8'h7E, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);

        // Asynchronous reset mid-run, asserted between clock edges.
        step(1, 8'hFF, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
        step(0, 8'h00, 0, 1);

        // Randomised sequences with stalls, stray starts and occasional aborts.
        for (int t = 0; t < 40; t++) begin
            rm = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rm = 8'h00;
            step(1, rm, 0, 1'($urandom_range(0, 1)));
            for (int c = 0; c < 60 && (m_run || m_fin); c++)
                step(1'($urandom_range(0, 3) == 0), 8'($urandom),
                     1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0));
            step(0, 8'h00, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
